// File: rtl/bayer_camera_tx_pkg.sv
// Shared types and widths for the Bayer camera transmit path.
package bayer_camera_tx_pkg;

  localparam int PIX_W   = 12;
  localparam int COORD_W = 12;
  localparam int BLANK_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VFRONT = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBACK  = 3'd4,
    ST_VBLANK = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PAT_RGGB = 2'd0,
    PAT_GRBG = 2'd1,
    PAT_GBRG = 2'd2,
    PAT_BGGR = 2'd3
  } bayer_pat_t;

endpackage

// File: rtl/bayer_mosaic_sel.sv
// Picks the Bayer sample for a pixel from its RGB components and tile position.
module bayer_mosaic_sel
  import bayer_camera_tx_pkg::*;
(
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] b,
  input  logic             x0,
  input  logic             y0,
  input  logic [1:0]       pattern,
  output logic [PIX_W-1:0] sample
);

  logic xe;
  logic ye;

  // Pattern code bit 0 shifts the tile by one column, bit 1 by one row; after
  // that shift every pattern reduces to RGGB.
  always_comb begin
    xe = x0 ^ pattern[0];
    ye = y0 ^ pattern[1];
    if (!xe && !ye) begin
      sample = r;
    end else if (xe && ye) begin
      sample = b;
    end else begin
      sample = g;
    end
  end

endmodule

// File: rtl/bayer_camera_tx.sv
// Sensor emulator: pulls RGB pixels and drives a framed raw Bayer stream (FVAL/LVAL/D).
module bayer_camera_tx
  import bayer_camera_tx_pkg::*;
#(
  parameter int VIDEO_W       = 1280,
  parameter int VIDEO_H       = 720,
  parameter int H_BLANK       = 160,
  parameter int V_FRONT       = 16,
  parameter int V_BACK        = 16,
  parameter int V_BLANK       = 1000,
  parameter int BAYER_PATTERN = 0
) (
  input  logic             CAMERA_PIXCLK,
  input  logic             reset_n,
  input  logic             ENABLE,
  input  logic [PIX_W-1:0] RGB_R,
  input  logic [PIX_W-1:0] RGB_G,
  input  logic [PIX_W-1:0] RGB_B,
  input  logic             RGB_VALID,
  output logic             RGB_READY,
  output logic             RGB_SOF,
  output logic [PIX_W-1:0] CAMERA_D,
  output logic             CAMERA_FVAL,
  output logic             CAMERA_LVAL,
  output logic [15:0]      FRAME_CNT,
  output logic             UNDERFLOW,
  output logic [2:0]       fsm_state
);

  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(VIDEO_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(VIDEO_H - 1);
  localparam logic [BLANK_W-1:0] HB_LAST = BLANK_W'(H_BLANK - 1);
  localparam logic [BLANK_W-1:0] VF_LAST = BLANK_W'(V_FRONT - 1);
  localparam logic [BLANK_W-1:0] VB_LAST = BLANK_W'(V_BACK - 1);
  localparam logic [BLANK_W-1:0] VK_LAST = BLANK_W'(V_BLANK - 1);
  localparam logic [1:0]         PAT     = 2'(BAYER_PATTERN);

  state_t             state, state_n;
  logic [COORD_W-1:0] x, x_n;
  logic [COORD_W-1:0] y, y_n;
  logic [BLANK_W-1:0] cnt, cnt_n;
  logic               frame_done;
  logic               active;
  logic               in_frame;
  logic [PIX_W-1:0]   sample;

  assign fsm_state = state;
  assign active    = (state == ST_ACTIVE);
  assign in_frame  = (state == ST_VFRONT) || (state == ST_ACTIVE) ||
                     (state == ST_HBLANK) || (state == ST_VBACK);

  // Pull strobe: the source is consumed on every active cycle, never stalled.
  assign RGB_READY = active;
  assign RGB_SOF   = active && (x == '0) && (y == '0);

  bayer_mosaic_sel u_mosaic (
    .r       (RGB_R),
    .g       (RGB_G),
    .b       (RGB_B),
    .x0      (x[0]),
    .y0      (y[0]),
    .pattern (PAT),
    .sample  (sample)
  );

  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    cnt_n      = cnt;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ENABLE) begin
          state_n = ST_VFRONT;
          cnt_n   = '0;
        end
      end
      ST_VFRONT: begin
        if (cnt == VF_LAST) begin
          state_n = ST_ACTIVE;
          cnt_n   = '0;
          x_n     = '0;
        end else begin
          cnt_n = cnt + BLANK_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (x == X_LAST) begin
          x_n     = '0;
          cnt_n   = '0;
          state_n = (y == Y_LAST) ? ST_VBACK : ST_HBLANK;
        end else begin
          x_n = x + COORD_W'(1);
        end
      end
      ST_HBLANK: begin
        if (cnt == HB_LAST) begin
          state_n = ST_ACTIVE;
          cnt_n   = '0;
          x_n     = '0;
          y_n     = y + COORD_W'(1);
        end else begin
          cnt_n = cnt + BLANK_W'(1);
        end
      end
      ST_VBACK: begin
        if (cnt == VB_LAST) begin
          state_n    = ST_VBLANK;
          cnt_n      = '0;
          frame_done = 1'b1;
        end else begin
          cnt_n = cnt + BLANK_W'(1);
        end
      end
      ST_VBLANK: begin
        if (cnt == VK_LAST) begin
          // ENABLE is only honoured here and in IDLE, so frames never truncate.
          state_n = ENABLE ? ST_VFRONT : ST_IDLE;
          cnt_n   = '0;
          y_n     = '0;
        end else begin
          cnt_n = cnt + BLANK_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        x_n     = '0;
        y_n     = '0;
      end
    endcase
  end

  always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      x     <= '0;
      y     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
      cnt   <= cnt_n;
    end
  end

  // D, LVAL and FVAL share one register stage so they stay cycle-aligned.
  always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      CAMERA_D    <= '0;
      CAMERA_LVAL <= 1'b0;
      CAMERA_FVAL <= 1'b0;
      FRAME_CNT   <= '0;
      UNDERFLOW   <= 1'b0;
    end else begin
      CAMERA_D    <= (active && RGB_VALID) ? sample : '0;
      CAMERA_LVAL <= active;
      CAMERA_FVAL <= in_frame;
      if (frame_done) begin
        FRAME_CNT <= FRAME_CNT + 16'd1;
      end
      if (active && !RGB_VALID) begin
        UNDERFLOW <= 1'b1;
      end else if ((state == ST_IDLE) && !ENABLE) begin
        UNDERFLOW <= 1'b0;
      end
    end
  end

endmodule
